// File: rtl/occupancy_grid_streamer_if.sv
// Grid-dump bus: RAM read port plus the valid/ready cell stream, bundled for the streamer.
// The master side belongs to the streamer; the slave side belongs to the RAM and the consumer.
interface occupancy_grid_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 15
);
    logic                  mem_read_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output mem_read_enable, mem_address, out_valid, out_data, out_last,
        input  mem_read_data, out_ready
    );

    modport slave (
        input  mem_read_enable, mem_address, out_valid, out_data, out_last,
        output mem_read_data, out_ready
    );
endinterface

// File: rtl/occupancy_grid_streamer.sv
// Row-major occupancy-grid dump; first beat 2 cycles after start, 1 beat/cycle; out_ready stalls reads via 2-entry buffer.
// GRID_STREAMER_CHECKSUM_EN appends an XOR-of-all-cells beat after the last cell.
module occupancy_grid_streamer #(
    parameter int GRID_WIDTH  = 256,
    parameter int GRID_HEIGHT = 128,
    parameter int DATA_WIDTH  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    occupancy_grid_streamer_if.master bus
);
    localparam int N          = GRID_WIDTH * GRID_HEIGHT;
    localparam int ADDR_WIDTH = $clog2(N);
`ifdef GRID_STREAMER_CHECKSUM_EN
    localparam int TOTAL = N + 1;
`else
    localparam int TOTAL = N;
`endif
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  issue, pop, fifo_pop, push, out_vld, out_lst, csum_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic [2:0]            occ_after;

`ifdef GRID_STREAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    // Checksum beat only once every cell has been delivered and nothing is left in flight.
    assign csum_vld = (state_q == DRAIN) && (count_q == 2'd0) && !inflight_q
                      && (out_cnt_q == CNT_W'(N));
`else
    assign csum_vld = 1'b0;
`endif

    // A returning read word bypasses the empty buffer so the first beat costs no extra cycle.
    assign out_vld = (count_q != 2'd0) || inflight_q || csum_vld;
    assign out_lst = out_vld && (out_cnt_q == CNT_W'(TOTAL - 1));
    assign pop     = out_vld && bus.out_ready;

    always_comb begin
        out_dat = '0;
        if (count_q != 2'd0) begin
            out_dat = fifo_q[rd_ptr_q];
        end else if (inflight_q) begin
            out_dat = bus.mem_read_data;
        end
`ifdef GRID_STREAMER_CHECKSUM_EN
        else if (csum_vld) begin
            out_dat = csum_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        out_cnt_d  = out_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_d     = fifo_q;
`ifdef GRID_STREAMER_CHECKSUM_EN
        csum_d     = csum_q;
        if (inflight_q) begin
            csum_d = csum_q ^ bus.mem_read_data;
        end
`endif
        fifo_pop  = pop && (count_q != 2'd0);
        push      = inflight_q && !(pop && (count_q == 2'd0));
        occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == READ) && (occ_after < 3'd2);
        inflight_d = issue;

        if (push) begin
            fifo_d[wr_ptr_q] = bus.mem_read_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(fifo_pop);
        if (pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        if (issue && (addr_q != ADDR_WIDTH'(N - 1))) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    addr_d    = '0;
                    out_cnt_d = '0;
`ifdef GRID_STREAMER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            READ:    if (issue && (addr_q == ADDR_WIDTH'(N - 1))) state_d = DRAIN;
            DRAIN:   if (pop && out_lst) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
`ifdef GRID_STREAMER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef GRID_STREAMER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.mem_read_enable = issue;
    assign bus.mem_address     = addr_q;
    assign bus.out_valid       = out_vld;
    assign bus.out_data        = out_dat;
    assign bus.out_last        = out_lst;
    assign busy                = (state_q != IDLE);
    assign done                = (state_q == DONE);
endmodule
